mbr_fifo: RTL and testbench

Parametrised memory buffer register for the image-downsampling processor: sits between data memory and the internal 16-bit bus, replacing the single-word MBR with a DEPTH-entry prefetch queue, a counted memory-fetch handshake and a store (write-back) path. Fetched pixels are queued and popped onto the bus on Read; the last fetched word is mirrored to the AR/PC side. A flush input discards queued and in-flight fetches on control-flow changes.

---
 rtl/mbr_fifo_if.sv | 37 +++
 rtl/mbr_fifo.sv | 125 ++++++++++++
 tb/tb_mbr_fifo.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/mbr_fifo_if.sv
// Bus bundle between the mbr_fifo prefetch buffer and its surroundings:
// the memory fetch/store handshakes and the internal bus read/write ports.
interface mbr_fifo_if #(
  parameter int DATA_W = 8,
  parameter int BUS_W  = 16
);
  logic              fetch;
  logic              flush;
  logic [DATA_W-1:0] in_bus;
  logic              mem_valid;
  logic              mem_req;
  logic              Read;
  logic [BUS_W-1:0]  out_bus;
  logic              out_valid;
  logic [DATA_W-1:0] AR_PC_MBR;
  logic              Write;
  logic [BUS_W-1:0]  cpu_bus;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_we;
  logic              mem_ack;
  logic              wr_busy;
  logic              full;
  logic              empty;
  logic              underflow;

  modport master (
    output fetch, flush, in_bus, mem_valid, Read, Write, cpu_bus, mem_ack,
    input  mem_req, out_bus, out_valid, AR_PC_MBR, mem_wdata, mem_we,
           wr_busy, full, empty, underflow
  );

  modport slave (
    input  fetch, flush, in_bus, mem_valid, Read, Write, cpu_bus, mem_ack,
    output mem_req, out_bus, out_valid, AR_PC_MBR, mem_wdata, mem_we,
           wr_busy, full, empty, underflow
  );
endinterface

// File: rtl/mbr_fifo.sv
// Memory buffer register with a DEPTH-entry prefetch queue. Fetches are
// counted as pending until memory returns them; full counts in-flight words
// so a return always has a free slot. A separate single-entry store path
// holds write-back data until memory acknowledges it.
module mbr_fifo #(
  parameter int DATA_W = 8,
  parameter int BUS_W  = 16,
  parameter int DEPTH  = 4
) (
  input logic       clk,
  input logic       reset,
  mbr_fifo_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] queue_mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  count, pending, count_nxt, pending_nxt;
  logic              issue, push, pop, full_c;

  logic [BUS_W-1:0]  out_bus_q;
  logic              out_valid_q;
  logic [DATA_W-1:0] ar_pc_q;
  logic              mem_req_q;
  logic              underflow_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic              mem_we_q;

  // Only the low DATA_W bits of cpu_bus are stored; the rest is don't-care.
  logic unused_cpu_bus;
  assign unused_cpu_bus = ^bus.cpu_bus;

  assign full_c = ({1'b0, count} + {1'b0, pending}) == (CNT_W + 1)'(DEPTH);
  assign issue  = bus.fetch && !full_c && !bus.flush;
  assign push   = bus.mem_valid && (pending != '0) && !bus.flush;
  assign pop    = bus.Read && (count != '0) && !bus.flush;

  // Next occupancy and in-flight counts from simultaneous push/pop/issue.
  always_comb begin
    count_nxt   = count;
    pending_nxt = pending;
    case ({push, pop})
      2'b10:   count_nxt = count + CNT_W'(1);
      2'b01:   count_nxt = count - CNT_W'(1);
      default: count_nxt = count;
    endcase
    case ({issue, push})
      2'b10:   pending_nxt = pending + CNT_W'(1);
      2'b01:   pending_nxt = pending - CNT_W'(1);
      default: pending_nxt = pending;
    endcase
  end

  // Queue storage; contents are only meaningful below count, so no reset.
  always_ff @(posedge clk) begin
    if (!reset && push)
      queue_mem[wr_ptr] <= bus.in_bus;
  end

  // Queue control, read port and sticky underflow.
  always_ff @(posedge clk) begin
    if (reset) begin
      count       <= '0;
      pending     <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      mem_req_q   <= 1'b0;
      out_bus_q   <= '0;
      out_valid_q <= 1'b0;
      ar_pc_q     <= '0;
      underflow_q <= 1'b0;
    end else begin
      out_bus_q   <= '0;
      out_valid_q <= 1'b0;
      if (bus.flush) begin
        count     <= '0;
        pending   <= '0;
        wr_ptr    <= '0;
        rd_ptr    <= '0;
        mem_req_q <= 1'b0;
      end else begin
        count     <= count_nxt;
        pending   <= pending_nxt;
        mem_req_q <= (pending_nxt != '0);
        if (push) begin
          wr_ptr  <= wr_ptr + PTR_W'(1);
          ar_pc_q <= bus.in_bus;
        end
        if (pop) begin
          rd_ptr      <= rd_ptr + PTR_W'(1);
          out_bus_q   <= BUS_W'(queue_mem[rd_ptr]);
          out_valid_q <= 1'b1;
        end else if (bus.Read) begin
          underflow_q <= 1'b1;
        end
      end
    end
  end

  // Store path: capture one word, hold it until memory acknowledges.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_we_q    <= 1'b0;
      mem_wdata_q <= '0;
    end else if (mem_we_q) begin
      if (bus.mem_ack)
        mem_we_q <= 1'b0;
    end else if (bus.Write) begin
      mem_wdata_q <= bus.cpu_bus[DATA_W-1:0];
      mem_we_q    <= 1'b1;
    end
  end

  assign bus.mem_req   = mem_req_q;
  assign bus.out_bus   = out_bus_q;
  assign bus.out_valid = out_valid_q;
  assign bus.AR_PC_MBR = ar_pc_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.wr_busy   = mem_we_q;
  assign bus.full      = full_c;
  assign bus.empty     = (count == '0);
  assign bus.underflow = underflow_q;
endmodule

// File: tb/tb_mbr_fifo.sv
// Directed bench for mbr_fifo (DATA_W=8, BUS_W=16, DEPTH=4).
module tb_mbr_fifo;
  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;

  mbr_fifo_if #(.DATA_W(8), .BUS_W(16)) bus ();

  mbr_fifo #(.DATA_W(8), .BUS_W(16), .DEPTH(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_in();
    bus.fetch     = 1'b0;
    bus.flush     = 1'b0;
    bus.in_bus    = 8'h00;
    bus.mem_valid = 1'b0;
    bus.Read      = 1'b0;
    bus.Write     = 1'b0;
    bus.cpu_bus   = 16'h0000;
    bus.mem_ack   = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    check_val({tag, " out_bus"},   32'(bus.out_bus),   32'h0);
    check_val({tag, " out_valid"}, 32'(bus.out_valid), 32'h0);
    check_val({tag, " AR_PC_MBR"}, 32'(bus.AR_PC_MBR), 32'h0);
    check_val({tag, " mem_req"},   32'(bus.mem_req),   32'h0);
    check_val({tag, " mem_we"},    32'(bus.mem_we),    32'h0);
    check_val({tag, " wr_busy"},   32'(bus.wr_busy),   32'h0);
    check_val({tag, " mem_wdata"}, 32'(bus.mem_wdata), 32'h0);
    check_val({tag, " underflow"}, 32'(bus.underflow), 32'h0);
    check_val({tag, " full"},      32'(bus.full),      32'h0);
    check_val({tag, " empty"},     32'(bus.empty),     32'h1);
  endtask

  logic [7:0] t1_data [4];
  logic [7:0] t2_exp  [3];

  initial begin
    n_checks = 0;
    n_errors = 0;
    t1_data = '{8'h11, 8'h22, 8'h33, 8'h44};
    t2_exp  = '{8'hA2, 8'hA3, 8'h55};
    clr_in();
    reset = 1'b1;
    tick();
    check_reset_vals("reset");
    tick();
    reset = 1'b0;

    // Fill: four fetches, a fifth while full, four returns, four reads
    bus.fetch = 1'b1;
    tick();
    check_val("t1 mem_req after fetch", 32'(bus.mem_req), 32'h1);
    tick(); tick(); tick();
    check_val("t1 full after 4 fetch", 32'(bus.full), 32'h1);
    tick();
    bus.fetch = 1'b0;
    bus.mem_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.in_bus = t1_data[i];
      tick();
      check_val("t1 AR_PC_MBR", 32'(bus.AR_PC_MBR), 32'(t1_data[i]));
    end
    bus.mem_valid = 1'b0;
    check_val("t1 mem_req after returns", 32'(bus.mem_req), 32'h0);
    check_val("t1 full with 4 queued", 32'(bus.full), 32'h1);
    check_val("t1 empty with 4 queued", 32'(bus.empty), 32'h0);
    bus.Read = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_val("t1 out_bus", 32'(bus.out_bus), 32'h0000_0000 | 32'(t1_data[i]));
      check_val("t1 out_valid", 32'(bus.out_valid), 32'h1);
    end
    check_val("t1 empty after drain", 32'(bus.empty), 32'h1);
    bus.Read = 1'b0;
    tick();
    check_val("t1 out_valid idle", 32'(bus.out_valid), 32'h0);
    check_val("t1 out_bus idle", 32'(bus.out_bus), 32'h0);
    check_val("t1 underflow clear", 32'(bus.underflow), 32'h0);

    // Push and pop in the same cycle with three queued
    bus.fetch = 1'b1;
    repeat (4) tick();
    bus.fetch = 1'b0;
    bus.mem_valid = 1'b1;
    bus.in_bus = 8'hA1; tick();
    bus.in_bus = 8'hA2; tick();
    bus.in_bus = 8'hA3; tick();
    bus.in_bus = 8'h55;
    bus.Read = 1'b1;
    tick();
    bus.mem_valid = 1'b0;
    check_val("t2 out_bus head", 32'(bus.out_bus), 32'h00A1);
    check_val("t2 out_valid", 32'(bus.out_valid), 32'h1);
    check_val("t2 AR_PC_MBR", 32'(bus.AR_PC_MBR), 32'h55);
    check_val("t2 full", 32'(bus.full), 32'h0);
    check_val("t2 mem_req", 32'(bus.mem_req), 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_val("t2 out_bus order", 32'(bus.out_bus), 32'(t2_exp[i]));
    end
    check_val("t2 empty after drain", 32'(bus.empty), 32'h1);
    bus.Read = 1'b0;
    tick();

    // Flush with 2 queued + 2 pending; same-cycle fetch/return/read dropped
    bus.fetch = 1'b1;
    repeat (4) tick();
    bus.fetch = 1'b0;
    bus.mem_valid = 1'b1;
    bus.in_bus = 8'hB1; tick();
    bus.in_bus = 8'hB2; tick();
    bus.mem_valid = 1'b0;
    check_val("t4 full 2+2", 32'(bus.full), 32'h1);
    bus.flush = 1'b1;
    bus.fetch = 1'b1;
    bus.Read = 1'b1;
    bus.mem_valid = 1'b1;
    bus.in_bus = 8'h98;
    tick();
    clr_in();
    check_val("t4 empty after flush", 32'(bus.empty), 32'h1);
    check_val("t4 full after flush", 32'(bus.full), 32'h0);
    check_val("t4 mem_req after flush", 32'(bus.mem_req), 32'h0);
    check_val("t4 out_valid flush read", 32'(bus.out_valid), 32'h0);
    check_val("t4 out_bus flush read", 32'(bus.out_bus), 32'h0);
    check_val("t4 underflow not set", 32'(bus.underflow), 32'h0);
    check_val("t4 AR_PC_MBR flush cycle", 32'(bus.AR_PC_MBR), 32'hB2);
    bus.mem_valid = 1'b1;
    bus.in_bus = 8'h99;
    tick();
    clr_in();
    check_val("t4 AR_PC_MBR late return", 32'(bus.AR_PC_MBR), 32'hB2);
    check_val("t4 empty late return", 32'(bus.empty), 32'h1);

    // Underflow: sticky across valid reads; no bypass on push into empty
    bus.Read = 1'b1;
    tick();
    bus.Read = 1'b0;
    check_val("t3 out_bus underflow", 32'(bus.out_bus), 32'h0);
    check_val("t3 out_valid underflow", 32'(bus.out_valid), 32'h0);
    check_val("t3 underflow set", 32'(bus.underflow), 32'h1);
    bus.fetch = 1'b1; tick(); bus.fetch = 1'b0;
    bus.mem_valid = 1'b1; bus.in_bus = 8'h66; tick(); bus.mem_valid = 1'b0;
    bus.Read = 1'b1; tick(); bus.Read = 1'b0;
    check_val("t3 out_bus 66", 32'(bus.out_bus), 32'h0066);
    check_val("t3 out_valid 66", 32'(bus.out_valid), 32'h1);
    check_val("t3 underflow held", 32'(bus.underflow), 32'h1);
    bus.fetch = 1'b1; tick(); bus.fetch = 1'b0;
    bus.mem_valid = 1'b1; bus.in_bus = 8'h77; bus.Read = 1'b1; tick();
    clr_in();
    check_val("t3 no bypass out_valid", 32'(bus.out_valid), 32'h0);
    check_val("t3 no bypass empty", 32'(bus.empty), 32'h0);
    bus.Read = 1'b1; tick(); bus.Read = 1'b0;
    check_val("t3 out_bus 77", 32'(bus.out_bus), 32'h0077);
    tick();

    // Store path
    bus.Write = 1'b1; bus.cpu_bus = 16'hABCD; tick();
    check_val("t5 mem_wdata CD", 32'(bus.mem_wdata), 32'hCD);
    check_val("t5 mem_we set", 32'(bus.mem_we), 32'h1);
    check_val("t5 wr_busy set", 32'(bus.wr_busy), 32'h1);
    bus.cpu_bus = 16'h1234; tick();
    check_val("t5 second write ignored", 32'(bus.mem_wdata), 32'hCD);
    bus.cpu_bus = 16'h5678; bus.mem_ack = 1'b1; tick();
    check_val("t5 mem_we after ack", 32'(bus.mem_we), 32'h0);
    check_val("t5 write in ack cycle ignored", 32'(bus.mem_wdata), 32'hCD);
    bus.mem_ack = 1'b0; tick();
    check_val("t5 new write accepted", 32'(bus.mem_wdata), 32'h78);
    check_val("t5 mem_we again", 32'(bus.mem_we), 32'h1);
    clr_in();
    bus.mem_ack = 1'b1; tick(); bus.mem_ack = 1'b0;
    check_val("t5 mem_we final ack", 32'(bus.mem_we), 32'h0);

    // Mid-stream reset during fetch, pop and store
    bus.fetch = 1'b1; repeat (2) tick(); bus.fetch = 1'b0;
    bus.mem_valid = 1'b1; bus.in_bus = 8'hC1; tick(); bus.mem_valid = 1'b0;
    bus.Write = 1'b1; bus.cpu_bus = 16'h00EE; tick(); bus.Write = 1'b0;
    check_val("t6 mem_req before reset", 32'(bus.mem_req), 32'h1);
    check_val("t6 mem_we before reset", 32'(bus.mem_we), 32'h1);
    reset = 1'b1;
    bus.fetch = 1'b1; bus.Read = 1'b1; bus.Write = 1'b1; bus.cpu_bus = 16'h1111;
    bus.mem_valid = 1'b1; bus.in_bus = 8'hC2;
    tick();
    check_reset_vals("t6 reset");
    clr_in();
    reset = 1'b0;
    bus.Read = 1'b1; tick(); bus.Read = 1'b0;
    check_val("t6 queue empty after reset", 32'(bus.out_valid), 32'h0);
    check_val("t6 underflow after reset", 32'(bus.underflow), 32'h1);
    tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
